scan_addr_sequencer: RTL

- Sequential address generator feeding the 3-to-8 decoder stage.
- Drives the decoder's 3-bit select `a` and enable `En`, so exactly one of the 8 decoder outputs is active at a time.
- Each output stays active for DWELL clocks, then the select steps up or down and wraps modulo 8.
- Used for LED/row scanning.

---
 rtl/scan_addr_sequencer_if.sv | 38 +++
 rtl/scan_addr_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scan_addr_sequencer_if.sv
// ---------------------------------------------------------------------------
// scan_addr_sequencer_if
//   Control and decoder-side bus of the scan address sequencer.
//   master : the controller (drives start/stop/dir/load/load_val, observes
//            the decoder select and status)
//   slave  : the sequencer itself
//   Signals:
//     start, stop, dir, load : control levels, sampled every clock
//     load_val[2:0]          : preset address for load
//     a[2:0], En             : registered select/enable to the 3-to-8 decoder
//     wrap                   : one-cycle pulse on address wrap
//     busy                   : high while the sequencer is not idle
//     oneshot                : single-sweep request (only with SCAN_ONESHOT_EN)
// ---------------------------------------------------------------------------
interface scan_addr_sequencer_if;
   logic       start;
   logic       stop;
   logic       dir;
   logic       load;
   logic [2:0] load_val;
   logic [2:0] a;
   logic       En;
   logic       wrap;
   logic       busy;
`ifdef SCAN_ONESHOT_EN
   logic       oneshot;

   modport master (output start, stop, dir, load, load_val, oneshot,
                   input  a, En, wrap, busy);
   modport slave  (input  start, stop, dir, load, load_val, oneshot,
                   output a, En, wrap, busy);
`else
   modport master (output start, stop, dir, load, load_val,
                   input  a, En, wrap, busy);
   modport slave  (input  start, stop, dir, load, load_val,
                   output a, En, wrap, busy);
`endif
endinterface

// File: rtl/scan_addr_sequencer.sv
// ---------------------------------------------------------------------------
// scan_addr_sequencer
//   Sequential address generator for a 3-to-8 decoder (LED/row scanning).
//   Each address is held DWELL clocks with En=1, then steps up or down
//   (modulo 8). All outputs are registered.
//
//   Parameters:
//     DWELL : clocks per address while running (1..65535)
//     CW    : dwell-counter width, 2**CW > DWELL-1
//   Ports:
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset
//     bus   : scan_addr_sequencer_if.slave (control in, decoder select out)
//
//   Optional build macro SCAN_ONESHOT_EN: adds bus.oneshot. When set at the
//   start sample, the step that would wrap instead ends the scan (a holds,
//   En drops, wrap pulses as the sweep-done indication).
// ---------------------------------------------------------------------------
module scan_addr_sequencer #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned CW    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   scan_addr_sequencer_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOPPING
   } state_t;

   localparam logic [CW-1:0] LP_CNT_LAST = CW'(DWELL - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    r_a;
   logic [2:0]    w_a_nxt;
   logic          r_en;
   logic          w_en_nxt;
   logic          r_wrap;
   logic          w_wrap_nxt;
   logic          r_busy;
   logic          w_busy_nxt;

   logic          w_last;
   logic [2:0]    w_a_step;
   logic          w_wrap_step;
   logic          w_sweep_done;

   assign w_last      = (r_cnt == LP_CNT_LAST);
   assign w_a_step    = bus.dir ? (r_a - 3'd1) : (r_a + 3'd1);
   assign w_wrap_step = bus.dir ? (r_a == 3'd0) : (r_a == 3'd7);

`ifdef SCAN_ONESHOT_EN
   logic r_oneshot;

   // Captured only at the start sample so a mid-scan change has no effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_oneshot <= 1'b0;
      end else if (r_state == ST_IDLE && bus.start) begin
         r_oneshot <= bus.oneshot;
      end
   end

   assign w_sweep_done = r_oneshot & w_wrap_step;
`else
   assign w_sweep_done = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_en    <= 1'b0;
         r_wrap  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_a     <= w_a_nxt;
         r_en    <= w_en_nxt;
         r_wrap  <= w_wrap_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // A finished one-shot sweep outranks a coincident stop.
            if (w_last && w_sweep_done) w_state_nxt = ST_IDLE;
            else if (bus.stop)          w_state_nxt = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (w_last) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and dwell counter
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_a_nxt    = r_a;
      w_en_nxt   = r_en;
      w_wrap_nxt = 1'b0;
      w_busy_nxt = r_busy;
      case (r_state)
         ST_IDLE: begin
            w_en_nxt   = 1'b0;
            w_busy_nxt = 1'b0;
            if (bus.load) w_a_nxt = bus.load_val;
            if (bus.start) begin
               w_cnt_nxt  = '0;
               w_en_nxt   = 1'b1;
               w_busy_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            w_en_nxt   = 1'b1;
            w_busy_nxt = 1'b1;
            if (w_last) begin
               w_cnt_nxt = '0;
               if (w_sweep_done) begin
                  // a holds the final address; wrap flags sweep completion.
                  w_en_nxt   = 1'b0;
                  w_busy_nxt = 1'b0;
                  w_wrap_nxt = 1'b1;
               end else begin
                  w_a_nxt    = w_a_step;
                  w_wrap_nxt = w_wrap_step;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_STOPPING: begin
            if (w_last) begin
               w_cnt_nxt  = '0;
               w_en_nxt   = 1'b0;
               w_busy_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_cnt_nxt  = '0;
            w_en_nxt   = 1'b0;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   assign bus.a    = r_a;
   assign bus.En   = r_en;
   assign bus.wrap = r_wrap;
   assign bus.busy = r_busy;

endmodule
